// File: rtl/bpa_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bpa_shift_sequencer
// Brief    : Sequential right-shift-reduce: acc >>= amt[k], one word per clock,
//            with start/result handshakes, abort and early zero termination.
// Revision : 1.0 - initial release
// ============================================================================
module bpa_shift_sequencer #(
  parameter int N_WORDS = 48,
  parameter int W       = 10,
  parameter int CNT_W   = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [W-1:0]         seed,
  input  logic [N_WORDS*W-1:0] amounts,
  input  logic                 abort,
  output logic [W-1:0]         result,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic                 busy,
  output logic                 early_zero,
  output logic [CNT_W-1:0]     steps
);

  localparam logic [1:0]       c_idle = 2'd0;
  localparam logic [1:0]       c_run  = 2'd1;
  localparam logic [1:0]       c_done = 2'd2;
  localparam logic [CNT_W-1:0] c_last = CNT_W'(N_WORDS - 1);
  localparam logic [W-1:0]     c_w    = W'(W);

  logic [1:0]           r_state;
  logic [W-1:0]         r_acc;
  logic [CNT_W-1:0]     r_k;
  logic [CNT_W-1:0]     r_steps;
  logic                 r_early_zero;
  logic [N_WORDS*W-1:0] r_bank;
  logic [W-1:0]         w_amt;
  logic [W-1:0]         w_shifted;

  assign w_amt     = r_bank[int'(r_k)*W +: W];
  // Amounts at or beyond the accumulator width flush it to zero.
  assign w_shifted = (w_amt >= c_w) ? '0 : (r_acc >> w_amt);

  // Shadow bank only matters after an accept, so it carries no reset.
  always_ff @(posedge clk) begin
    if (r_state == c_idle && start_valid && !rst) begin
      r_bank <= amounts;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= c_idle;
      r_acc        <= '0;
      r_k          <= '0;
      r_steps      <= '0;
      r_early_zero <= 1'b0;
    end else begin
      case (r_state)
        c_idle: begin
          if (start_valid) begin
            r_acc        <= seed;
            r_k          <= '0;
            r_steps      <= '0;
            r_early_zero <= 1'b0;
            r_state      <= c_run;
          end
        end
        c_run: begin
          if (abort) begin
            r_state      <= c_idle;
            r_steps      <= '0;
            r_early_zero <= 1'b0;
          end else if (r_acc == '0) begin
            r_state      <= c_done;
            r_early_zero <= 1'b1;
          end else begin
            r_acc   <= w_shifted;
            r_k     <= r_k + 1'b1;
            r_steps <= r_steps + 1'b1;
            if (r_k == c_last) begin
              r_state <= c_done;
            end
          end
        end
        c_done: begin
          if (abort) begin
            r_state      <= c_idle;
            r_steps      <= '0;
            r_early_zero <= 1'b0;
          end else if (result_ready) begin
            r_state <= c_idle;
          end
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  assign start_ready  = (r_state == c_idle) && !rst;
  assign result_valid = (r_state == c_done);
  assign busy         = (r_state != c_idle);
  assign result       = r_acc;
  assign early_zero   = r_early_zero;
  assign steps        = r_steps;

endmodule
`default_nettype wire

// File: tb/tb_bpa_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bpa_shift_sequencer
// Brief    : Directed self-checking bench for bpa_shift_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bpa_shift_sequencer;

  localparam int N  = 48;
  localparam int W  = 10;
  localparam int CW = 6;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start_valid = 1'b0;
  logic           abort = 1'b0;
  logic           result_ready = 1'b0;
  logic [W-1:0]   seed = '0;
  logic [N*W-1:0] amounts = '0;
  logic           start_ready;
  logic [W-1:0]   result;
  logic           result_valid;
  logic           busy;
  logic           early_zero;
  logic [CW-1:0]  steps;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc;

  bpa_shift_sequencer #(.N_WORDS(N), .W(W), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .seed         (seed),
    .amounts      (amounts),
    .abort        (abort),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .busy         (busy),
    .early_zero   (early_zero),
    .steps        (steps)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [N*W-1:0] mk_bank(input logic [W-1:0] a0, input logic [W-1:0] a1,
                                              input logic [W-1:0] fill);
    logic [N*W-1:0] b;
    for (int i = 0; i < N; i++) b[i*W +: W] = fill;
    b[W-1:0]   = a0;
    b[2*W-1:W] = a1;
    return b;
  endfunction

  // Leaves the bench at the negedge following the accept edge E0.
  task automatic start_run(input logic [W-1:0] s, input logic [N*W-1:0] bank);
    @(negedge clk);
    check("ready before start", start_ready, 1);
    seed        = s;
    amounts     = bank;
    start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!result_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!result_valid) check("done timeout", 0, 1);
  endtask

  task automatic wait_steps(input int target);
    int t;
    t = 0;
    while (int'(steps) != target && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (int'(steps) != target) check("steps timeout", steps, target);
  endtask

  task automatic ack();
    result_ready = 1'b1;
    @(negedge clk);
    check("idle after ack", {busy, result_valid, start_ready}, 3'b001);
    result_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    check("ready in rst", start_ready, 0);
    check("reset outs", {result, result_valid, busy, early_zero, steps}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready after rst", start_ready, 1);

    // All-zero amounts: full latency, value unchanged
    start_run(10'h3FF, mk_bank(0, 0, 0));
    check("busy in run", {busy, start_ready}, 2'b10);
    wait_done(cyc);
    check("full latency", cyc, 48);
    check("zero amt result", result, 10'h3FF);
    check("zero amt steps", steps, 48);
    check("zero amt early", early_zero, 0);
    ack();

    // Partial shifts, inputs disturbed during RUN
    start_run(10'h3FF, mk_bank(1, 2, 0));
    repeat (3) @(negedge clk);
    amounts = '1;
    seed    = '1;
    wait_done(cyc);
    check("partial result", result, 10'h07F);
    check("partial steps", steps, 48);

    // Backpressure in DONE with start pulses
    for (int i = 0; i < 5; i++) begin
      start_valid = (i % 2 == 0);
      @(negedge clk);
      check("bp hold", {result, result_valid, start_ready, busy}, {10'h07F, 3'b101});
    end
    start_valid = 1'b0;
    ack();
    start_run(10'h200, mk_bank(9, 0, 0));
    wait_done(cyc);
    check("post bp latency", cyc, 48);
    check("post bp result", result, 10'h001);
    ack();

    // Saturating shift
    start_run(10'h3FF, mk_bank(10, 0, 0));
    wait_done(cyc);
    check("sat latency", cyc, 2);
    check("sat result", result, 0);
    check("sat steps", steps, 1);
    check("sat early", early_zero, 1);
    ack();

    // Zero seed
    start_run(10'h000, mk_bank(3, 0, 0));
    wait_done(cyc);
    check("zseed latency", cyc, 1);
    check("zseed steps", steps, 0);
    check("zseed early", early_zero, 1);
    ack();

    // Abort at step 20
    start_run(10'h3FF, mk_bank(0, 0, 0));
    wait_steps(20);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort idle", {busy, result_valid, start_ready}, 3'b001);
    check("abort steps", steps, 0);
    check("abort early", early_zero, 0);
    start_run(10'h155, mk_bank(1, 1, 1));
    wait_done(cyc);
    check("after abort latency", cyc, 10);
    check("after abort result", result, 0);
    check("after abort early", early_zero, 1);
    check("after abort steps", steps, 9);

    // Abort together with result_ready in DONE
    abort        = 1'b1;
    result_ready = 1'b1;
    @(negedge clk);
    abort        = 1'b0;
    result_ready = 1'b0;
    check("abort+ack", {busy, result_valid, early_zero, steps}, 0);

    // Reset mid-run
    start_run(10'h3FF, mk_bank(0, 0, 0));
    wait_steps(30);
    rst = 1'b1;
    #1;
    check("ready low in rst", start_ready, 0);
    @(negedge clk);
    check("midrun reset outs", {result, result_valid, busy, early_zero, steps}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready after midrun rst", start_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bpa_shift_sequencer.md
# bpa_shift_sequencer

Sequential controller for the blocking right-shift-reduce datapath. It captures a seed and a bank of 48 ten-bit shift amounts, then applies `acc >>= amt[k]` one word per clock instead of unrolling all 48 stages combinationally. Start and result use valid/ready handshakes, and the block terminates early once the accumulator reaches zero. The block is triplicated by default under TMRG and sits between the configuration/stimulus source and the consumer of the reduced 10-bit result.

## Interface
- `N_WORDS`, default 48: number of shift amounts in the bank.
- `W`, default 10: accumulator width and width of each shift amount.
- `CNT_W`, default 6: width of the step counter; must satisfy 2^CNT_W > N_WORDS.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start_valid` in 1: request to start a reduction.
- `start_ready` out 1: block can accept a start.
- `seed` in W: initial accumulator value.
- `amounts` in N_WORDS*W: word k is `amounts[k*W +: W]`, an unsigned shift amount.
- `abort` in 1: cancels the current operation.
- `result` out W: reduced value.
- `result_valid` out 1: `result` is valid.
- `result_ready` in 1: consumer accepts `result`.
- `busy` out 1: high in RUN or DONE.
- `early_zero` out 1: the run ended on zero detection, before all N_WORDS steps.
- `steps` out CNT_W: number of shifts actually applied.

## Operation
States:
- **IDLE**
  - `start_ready` = 1.
  - On `start_valid`: `acc` <= `seed`, shadow bank <= `amounts`, `k` <= 0, `steps` <= 0, `early_zero` <= 0, go to RUN.
- **RUN**, evaluated once per edge, in this order:
  - If `acc` == 0 (registered value): go to DONE, `early_zero` <= 1, no shift.
  - Otherwise: `acc` <= `acc` >> shadow[k]; `k`++; `steps`++.
  - If this was step k == N_WORDS-1: go to DONE, `early_zero` stays 0.
- **DONE**
  - `result_valid` = 1, `result` = `acc`, held stable.
  - On `result_ready`: go to IDLE.
  - `start_ready` = 0.

Arithmetic and width rules:
- Shift amounts are unsigned, range 0..2^W-1.
- Any amount >= W yields 0.
- Logical right shift; the vacated MSBs fill with zero.
- `acc` never grows and is never sign-extended.

Input capture:
- `amounts` and `seed` are sampled only on the accept edge.
- Changes to either input during RUN or DONE have no effect.

`abort`:
- In RUN or DONE: next state is IDLE, `result_valid` drops, `steps` and `early_zero` are cleared.
- In IDLE: ignored.
- Priority is above every other event except `rst`.

Other rules:
- `start_valid` while not in IDLE is ignored. Requests do not queue.
- `busy` = (state != IDLE).

## Timing
- Reset values: state IDLE, `acc` 0, `result` 0, `result_valid` 0, `busy` 0, `early_zero` 0, `steps` 0.
- `start_ready` is forced to 0 while `rst` is high and is 1 in the first cycle after reset.
- Accept edge E0 (`start_valid` & `start_ready`).
- Shifts are applied on edges E1..E_N_WORDS.
- Full-run latency: `result_valid` is high after edge E48, which is 48 cycles after accept.
- Early zero: if `acc` first reads zero before edge Ej, the block enters DONE at Ej with `steps` = j-1.
- Zero seed: DONE at E1 with `steps` = 0.
- Result handshake completes on the edge where `result_valid` & `result_ready` are both high.
- `start_ready` rises in the cycle after that handshake edge, so the minimum start-to-start spacing is latency + 2 cycles.
- `rst` mid-RUN or mid-DONE: all outputs take their reset values at that edge, and the shadow bank contents become don't-care.
- If `abort` and `result_ready` are both high in DONE, the block goes to IDLE with identical effect.

## Test plan
- **All-zero amounts:** seed 10'h3FF, all amounts 0 -> `result_valid` after E48, `result` 10'h3FF, `steps` 48, `early_zero` 0.
- **Partial shifts:** seed 10'h3FF, amt[0]=1, amt[1]=2, rest 0 -> `result` 10'h07F, `steps` 48. Also drive `amounts` to all-ones during RUN -> `result` unchanged.
- **Saturating shift and zero seed:**
  - seed 10'h3FF, amt[0]=10 -> `acc` 0 after E1, DONE at E2, `result` 0, `steps` 1, `early_zero` 1.
  - seed 0 -> DONE at E1, `steps` 0, `early_zero` 1.
- **Backpressure:** hold `result_ready` low 5 cycles in DONE while pulsing `start_valid` -> `result` stable, `start_ready` 0, no new run. Then raise `result_ready` -> IDLE next edge, and the next start is accepted.
- **Abort:** assert `abort` at RUN step 20 -> IDLE next edge, `result_valid` never asserted, `steps` 0. A following start with seed 10'h155, all amounts 1 -> `result` 0, `early_zero` 1, `steps` 9.
- **Reset mid-run:** assert `rst` at RUN step 30 -> all outputs at reset values next edge, `start_ready` 1 the cycle after `rst` deasserts.
